security_sequencer: RTL and testbench

SECURITY_SEQUENCER -- requirements
Module: security_sequencer

---
 rtl/sec_pkg.sv | 29 ++
 rtl/bcd_digit_check.sv | 19 +
 rtl/security_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_security_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sec_pkg.sv
// Shared types and constants for the keypad security sequencer.
package sec_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned CODE_W     = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] BCD_MAX          = 4'd9;
  localparam logic [CODE_W-1:0]  SEC_DEFAULT_CODE = 12'h123;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_PROGRAM,
    S_LOCKOUT,
    S_FIRE
  } state_e;

  typedef enum logic [1:0] {
    DIG_MISMATCH,
    DIG_MATCH,
    DIG_BAD
  } digit_status_e;

endpackage

// File: rtl/bcd_digit_check.sv
// Classifies one digit against a reference: non-BCD, equal, or different.
module bcd_digit_check
  import sec_pkg::*;
(
  input  digit_t        digit,
  input  digit_t        ref_digit,
  output digit_status_e status
);

  always_comb begin
    if (digit > BCD_MAX)
      status = DIG_BAD;
    else if (digit == ref_digit)
      status = DIG_MATCH;
    else
      status = DIG_MISMATCH;
  end

endmodule

// File: rtl/security_sequencer.sv
// Keypad door controller: 3-digit code entry, lockout after repeated failures,
// code reprogramming while unlocked, and a fire override that releases everything.
module security_sequencer
  import sec_pkg::*;
#(
  parameter int unsigned        MAX_FAILS      = 3,
  parameter int unsigned        LOCKOUT_CYCLES = 16,
  parameter logic [CODE_W-1:0]  DEFAULT_CODE   = SEC_DEFAULT_CODE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               lock_cmd,
  input  logic               prog_mode,
  input  logic               motion_sensor,
  input  logic               fire_detector,
  input  logic [3:0]         remote,
  output logic               unlocked,
  output logic [3:0]         devices,
  output logic               alarm,
  output logic               lockout,
  output logic               err_digit
);

  localparam int unsigned FAIL_W   = $clog2(MAX_FAILS + 1);
  localparam int unsigned TIMER_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [1:0]  LAST_POS = 2'(NUM_DIGITS - 1);

  state_e              state_q, state_d;
  logic [1:0]          pos_q, pos_d;
  digit_t              entry_q [NUM_DIGITS];
  digit_t              entry_d [NUM_DIGITS];
  digit_t              code_q  [NUM_DIGITS];
  digit_t              code_d  [NUM_DIGITS];
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                err_d;
  logic [3:0]          devices_d;

  digit_status_e check_status [NUM_DIGITS];
  digit_status_e key_status;
  logic          code_match, key_bad, key_ok;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_check
    bcd_digit_check u_check (
      .digit     (entry_q[g]),
      .ref_digit (code_q[g]),
      .status    (check_status[g])
    );
  end

  bcd_digit_check u_key_check (
    .digit     (key_digit),
    .ref_digit ('0),
    .status    (key_status)
  );

  assign key_bad = key_valid && (key_status == DIG_BAD);
  assign key_ok  = key_valid && (key_status != DIG_BAD);

  always_comb begin
    code_match = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (check_status[i] != DIG_MATCH) code_match = 1'b0;
  end

  // entry_q doubles as the new-code buffer while in PROGRAM
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    entry_d = entry_q;
    code_d  = code_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    err_d   = 1'b0;

    if (fire_detector) begin
      state_d = S_FIRE;
      pos_d   = '0;
      fail_d  = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_LOCKED, S_ENTRY: begin
          if (key_bad) begin
            err_d   = 1'b1;
            pos_d   = '0;
            state_d = S_LOCKED;
          end else if (key_ok) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
              if (pos_q == 2'(i)) entry_d[i] = key_digit;
            if (pos_q == LAST_POS) begin
              pos_d   = '0;
              state_d = S_CHECK;
            end else begin
              pos_d   = pos_q + 2'd1;
              state_d = S_ENTRY;
            end
          end
        end
        S_CHECK: begin
          if (code_match) begin
            state_d = S_UNLOCKED;
            fail_d  = '0;
          end else if (fail_q >= FAIL_W'(MAX_FAILS - 1)) begin
            state_d = S_LOCKOUT;
            fail_d  = FAIL_W'(MAX_FAILS);
            timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = S_LOCKED;
            fail_d  = fail_q + FAIL_W'(1);
          end
        end
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            state_d = S_LOCKED;
            fail_d  = '0;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        S_UNLOCKED: begin
          if (lock_cmd) begin
            state_d = S_LOCKED;
          end else if (key_valid && prog_mode) begin
            if (key_bad) begin
              err_d = 1'b1;
            end else begin
              entry_d[0] = key_digit;
              pos_d      = 2'd1;
              state_d    = S_PROGRAM;
            end
          end
        end
        S_PROGRAM: begin
          if (lock_cmd) begin
            pos_d   = '0;
            state_d = S_LOCKED;
          end else if (key_bad) begin
            err_d   = 1'b1;
            pos_d   = '0;
            state_d = S_UNLOCKED;
          end else if (key_ok) begin
            if (pos_q == LAST_POS) begin
              for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++)
                code_d[i] = entry_q[i];
              code_d[NUM_DIGITS-1] = key_digit;
              pos_d   = '0;
              state_d = S_UNLOCKED;
            end else begin
              for (int unsigned i = 0; i < NUM_DIGITS; i++)
                if (pos_q == 2'(i)) entry_d[i] = key_digit;
              pos_d = pos_q + 2'd1;
            end
          end
        end
        S_FIRE:  state_d = S_LOCKED;
        default: state_d = S_LOCKED;
      endcase
    end

    unique case (state_d)
      S_UNLOCKED: devices_d = remote ^ {4{motion_sensor}};
      S_FIRE:     devices_d = '1;
      default:    devices_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_LOCKED;
      pos_q     <= '0;
      entry_q   <= '{default: '0};
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        code_q[i] <= DEFAULT_CODE[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
      fail_q    <= '0;
      timer_q   <= '0;
      unlocked  <= 1'b0;
      devices   <= '0;
      alarm     <= 1'b0;
      lockout   <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      entry_q   <= entry_d;
      code_q    <= code_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      unlocked  <= (state_d == S_UNLOCKED) || (state_d == S_FIRE);
      devices   <= devices_d;
      alarm     <= (state_d == S_FIRE);
      lockout   <= (state_d == S_LOCKOUT);
      err_digit <= err_d;
    end
  end

endmodule

// File: tb/tb_security_sequencer.sv
// Self-checking bench for security_sequencer: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_security_sequencer;

  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, key_valid = 1'b0, lock_cmd = 1'b0, prog_mode = 1'b0;
  logic       motion_sensor = 1'b0, fire_detector = 1'b0;
  logic [3:0] key_digit = '0, remote = '0;
  logic       unlocked, alarm, lockout, err_digit;
  logic [3:0] devices;

  security_sequencer #(
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .DEFAULT_CODE   (12'h123)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid     (key_valid),
    .key_digit     (key_digit),
    .lock_cmd      (lock_cmd),
    .prog_mode     (prog_mode),
    .motion_sensor (motion_sensor),
    .fire_detector (fire_detector),
    .remote        (remote),
    .unlocked      (unlocked),
    .devices       (devices),
    .alarm         (alarm),
    .lockout       (lockout),
    .err_digit     (err_digit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode name, digits typed so far, stored code.
  string      mode = "LOCKED";
  int         entered[$];
  int         newcode[$];
  int         code[3] = '{1, 2, 3};
  int         fails = 0;
  int         lo_rem = 0;
  bit         m_unl, m_alarm, m_lo, m_err;
  logic [3:0] m_dev;

  task automatic model_edge();
    m_err = 1'b0;
    if (!rst_n) begin
      mode = "LOCKED"; entered.delete(); newcode.delete();
      code = '{1, 2, 3}; fails = 0; lo_rem = 0;
    end else if (fire_detector) begin
      mode = "FIRE"; entered.delete(); newcode.delete(); fails = 0; lo_rem = 0;
    end else if (mode == "FIRE") begin
      mode = "LOCKED";
    end else if (mode == "LOCKED" || mode == "ENTRY") begin
      if (key_valid) begin
        if (key_digit > 9) begin
          m_err = 1'b1; entered.delete(); mode = "LOCKED";
        end else begin
          entered.push_back(int'(key_digit));
          mode = (entered.size() == 3) ? "CHECK" : "ENTRY";
        end
      end
    end else if (mode == "CHECK") begin
      if (entered[0] == code[0] && entered[1] == code[1] && entered[2] == code[2]) begin
        mode = "UNLOCKED"; fails = 0;
      end else begin
        fails = (fails < MAX_FAILS) ? fails + 1 : MAX_FAILS;
        if (fails == MAX_FAILS) begin
          mode = "LOCKOUT"; lo_rem = LOCKOUT_CYCLES;
        end else begin
          mode = "LOCKED";
        end
      end
      entered.delete();
    end else if (mode == "LOCKOUT") begin
      lo_rem--;
      if (lo_rem == 0) begin mode = "LOCKED"; fails = 0; end
    end else if (mode == "UNLOCKED") begin
      if (lock_cmd) mode = "LOCKED";
      else if (key_valid && prog_mode) begin
        if (key_digit > 9) m_err = 1'b1;
        else begin newcode.delete(); newcode.push_back(int'(key_digit)); mode = "PROGRAM"; end
      end
    end else if (mode == "PROGRAM") begin
      if (lock_cmd) begin
        mode = "LOCKED"; newcode.delete();
      end else if (key_valid) begin
        if (key_digit > 9) begin
          m_err = 1'b1; mode = "UNLOCKED"; newcode.delete();
        end else begin
          newcode.push_back(int'(key_digit));
          if (newcode.size() == 3) begin
            for (int i = 0; i < 3; i++) code[i] = newcode[i];
            newcode.delete(); mode = "UNLOCKED";
          end
        end
      end
    end
    m_unl   = (mode == "UNLOCKED") || (mode == "FIRE");
    m_alarm = (mode == "FIRE");
    m_lo    = (mode == "LOCKOUT");
    m_dev   = (mode == "UNLOCKED") ? (remote ^ {4{motion_sensor}}) :
              (mode == "FIRE") ? 4'hF : 4'h0;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit fi, input bit kv, input logic [3:0] kd,
                      input bit lc, input bit pm, input bit mo, input logic [3:0] rm);
    rst_n = r; fire_detector = fi; key_valid = kv; key_digit = kd;
    lock_cmd = lc; prog_mode = pm; motion_sensor = mo; remote = rm;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_unlocked", {3'b0, unlocked},  {3'b0, m_unl});
    chk("model_devices",  devices,           m_dev);
    chk("model_alarm",    {3'b0, alarm},     {3'b0, m_alarm});
    chk("model_lockout",  {3'b0, lockout},   {3'b0, m_lo});
    chk("model_err",      {3'b0, err_digit}, {3'b0, m_err});
  endtask

  task automatic idle();                    step(1, 0, 0, 4'h0, 0, 0, 0, 4'h0); endtask
  task automatic key(input logic [3:0] d);  step(1, 0, 1, d,    0, 0, 0, 4'h0); endtask
  task automatic pkey(input logic [3:0] d); step(1, 0, 1, d,    0, 1, 0, 4'h0); endtask
  task automatic relock();                  step(1, 0, 0, 4'h0, 1, 0, 0, 4'h0); endtask
  task automatic reset_cycle();             step(0, 0, 0, 4'h0, 0, 0, 0, 4'h0); endtask
  task automatic fire(input bit kv);        step(1, 1, kv, 4'h1, 0, 0, 0, 4'h0); endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    key(a); key(b); key(c); idle();
  endtask

  typedef struct {
    bit r, fi, kv; logic [3:0] kd; bit lc, pm, mo; logic [3:0] rm;
    bit unl; logic [3:0] dev; bit al, lo, er;
  } vec_t;

  vec_t vecs[$];

  initial begin : main
    int  cnt;
    bit  seen_unl;
    bit  r, fi, kv, lc, pm, mo;
    logic [3:0] kd, rm;

    //              r fi kv kd    lc pm mo rm     unl dev   al lo er
    vecs.push_back('{0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'h1, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'h2, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'h3, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'h0, 0, 0, 1, 4'h5, 1, 4'hA, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'h0, 0, 0, 0, 4'h5, 1, 4'h5, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'h2, 1, 1, 0, 4'h5, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'h1, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'hC, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 1});
    vecs.push_back('{1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'h1, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'h2, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'h3, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'h0, 0, 0, 0, 4'h3, 1, 4'h3, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 4'h0, 0, 0, 0, 4'h3, 1, 4'hF, 1, 0, 0});
    vecs.push_back('{1, 1, 1, 4'h1, 0, 0, 0, 4'h0, 1, 4'hF, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0});

    #1;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].fi, vecs[i].kv, vecs[i].kd, vecs[i].lc, vecs[i].pm,
           vecs[i].mo, vecs[i].rm);
      chk("tbl_unlocked", {3'b0, unlocked},  {3'b0, vecs[i].unl});
      chk("tbl_devices",  devices,           vecs[i].dev);
      chk("tbl_alarm",    {3'b0, alarm},     {3'b0, vecs[i].al});
      chk("tbl_lockout",  {3'b0, lockout},   {3'b0, vecs[i].lo});
      chk("tbl_err",      {3'b0, err_digit}, {3'b0, vecs[i].er});
    end

    // Bad digit is not a failed attempt: two wrong codes afterwards must not lock out.
    reset_cycle();
    key(4'h1); key(4'hC);
    enter(4'h4, 4'h5, 4'h6); enter(4'h4, 4'h5, 4'h6); enter(4'h1, 4'h2, 4'h3);
    chk("err_not_fail_unlocked", {3'b0, unlocked}, 4'h1);
    chk("err_not_fail_lockout",  {3'b0, lockout},  4'h0);

    // Lockout lasts exactly LOCKOUT_CYCLES and ignores keys.
    reset_cycle();
    repeat (3) enter(4'h4, 4'h5, 4'h6);
    chk("lockout_on", {3'b0, lockout}, 4'h1);
    cnt = 1; seen_unl = 1'b0;
    for (int i = 0; i < 40 && lockout; i++) begin
      if (i < 9) key(4'((i % 3) + 1)); else idle();
      if (lockout) cnt++;
      if (unlocked) seen_unl = 1'b1;
    end
    chk("lockout_len", 4'(cnt), 4'(LOCKOUT_CYCLES));
    chk("lockout_no_unlock", {3'b0, seen_unl}, 4'h0);
    enter(4'h1, 4'h2, 4'h3);
    chk("after_lockout_unlock", {3'b0, unlocked}, 4'h1);

    // Fire mid-entry clears the partial code.
    relock(); key(4'h1);
    fire(1'b0);
    chk("fire_entry_alarm", {3'b0, alarm}, 4'h1);
    chk("fire_entry_unl", {3'b0, unlocked}, 4'h1);
    chk("fire_entry_dev", devices, 4'hF);
    fire(1'b1); idle();
    chk("fire_fall_alarm", {3'b0, alarm}, 4'h0);
    chk("fire_fall_unl", {3'b0, unlocked}, 4'h0);
    enter(4'h1, 4'h2, 4'h3);
    chk("fire_entry_cleared", {3'b0, unlocked}, 4'h1);

    // Fire during lockout.
    relock();
    repeat (3) enter(4'h4, 4'h5, 4'h6);
    idle(); idle();
    fire(1'b0);
    chk("fire_lo_alarm", {3'b0, alarm}, 4'h1);
    chk("fire_lo_lockout", {3'b0, lockout}, 4'h0);
    chk("fire_lo_dev", devices, 4'hF);
    idle();
    chk("fire_lo_fall", {3'b0, alarm | unlocked | lockout}, 4'h0);

    // Reprogram to 7,8,9 then exercise both codes.
    enter(4'h1, 4'h2, 4'h3);
    pkey(4'h7); key(4'h8); key(4'h9);
    chk("prog_stays_unl", {3'b0, unlocked}, 4'h1);
    relock();
    enter(4'h1, 4'h2, 4'h3);
    chk("old_code_rejected", {3'b0, unlocked}, 4'h0);
    enter(4'h7, 4'h8, 4'h9);
    chk("new_code_accepted", {3'b0, unlocked}, 4'h1);

    // Aborted programming leaves the code unchanged.
    pkey(4'h4); key(4'hA);
    chk("prog_abort_err", {3'b0, err_digit}, 4'h1);
    chk("prog_abort_unl", {3'b0, unlocked}, 4'h1);
    pkey(4'h4); key(4'h5); relock();
    chk("prog_lock_abort", {3'b0, unlocked}, 4'h0);
    enter(4'h7, 4'h8, 4'h9);
    chk("code_kept", {3'b0, unlocked}, 4'h1);

    // Reset restores the default code and discards a lockout in progress.
    reset_cycle();
    enter(4'h1, 4'h2, 4'h3);
    chk("reset_default_code", {3'b0, unlocked}, 4'h1);
    relock();
    repeat (3) enter(4'h4, 4'h5, 4'h6);
    idle(); reset_cycle();
    chk("reset_clears_lockout", {3'b0, lockout}, 4'h0);
    enter(4'h1, 4'h2, 4'h3);
    chk("reset_mid_lockout_unl", {3'b0, unlocked}, 4'h1);

    // Randomized run; half the digits follow the stored code to reach deep states.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      fi = ($urandom_range(0, 79) == 0);
      kv = ($urandom_range(0, 2) != 0);
      lc = ($urandom_range(0, 19) == 0);
      pm = ($urandom_range(0, 3) == 0);
      mo = 1'($urandom_range(0, 1));
      rm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1 && entered.size() < 3)
        kd = 4'(code[entered.size()]);
      else
        kd = 4'($urandom_range(0, 15));
      step(r, fi, kv, kd, lc, pm, mo, rm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
